// File: rtl/fc_event_pkg.sv
// Shared constants, types and helpers for the FC event queue.
// Holds the default parameter values and the drop counter width.
package fc_event_pkg;

    localparam int NB_EVT_DEFAULT         = 32;
    localparam int EVENT_ID_WIDTH_DEFAULT = 8;
    localparam int FIFO_DEPTH_DEFAULT     = 4;
    localparam int ID_OFFSET_DEFAULT      = 0;

    // Width of the lost-event counter exposed on drop_cnt_o.
    localparam int DROP_CNT_WIDTH = 16;

    typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = '1;

    // Queue occupancy flags derived from the entry count.
    typedef struct packed {
        logic full;
        logic empty;
    } fifo_status_t;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturating add used by the drop counter.
    function automatic drop_cnt_t drop_cnt_sat_add(input drop_cnt_t cnt, input int unsigned inc);
        logic [32:0] sum;
        sum = {{(33-DROP_CNT_WIDTH){1'b0}}, cnt} + {1'b0, inc};
        if (sum > {{(33-DROP_CNT_WIDTH){1'b0}}, DROP_CNT_MAX}) begin
            return DROP_CNT_MAX;
        end
        return sum[DROP_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fc_event_queue_if.sv
// Valid/full-not handshake between the event queue and the FC interrupt
// controller. The queue side is the master (drives valid and data), the
// FC side is the slave (drives fulln, high when it can accept an ID).
interface fc_event_queue_if
    import fc_event_pkg::*;
#(
    parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEFAULT
) ();

    logic                      valid;
    logic                      fulln;
    logic [EVENT_ID_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  fulln
    );

    modport slave (
        input  valid,
        input  data,
        output fulln
    );

endinterface

// File: rtl/fc_event_queue_fifo.sv
// Event ID queue in front of the FC interrupt controller.
// The head entry is presented directly so an ID pushed at one edge is
// visible right after it; push is accepted when not full, or when full
// and the FC pops in the same cycle.
module fc_event_queue_fifo
    import fc_event_pkg::*;
#(
    parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push,
    input  logic [EVENT_ID_WIDTH-1:0] push_data,
    output logic                      can_push,
    fc_event_queue_if.master          fc
);

    localparam int PTR_W = idx_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [EVENT_ID_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    fifo_status_t              status;
    logic                      pop;
    logic                      push_ok;

    assign status.empty = (count_reg == '0);
    assign status.full  = (count_reg == CNT_W'(FIFO_DEPTH));

    assign pop      = !status.empty && fc.fulln;
    assign can_push = !status.full || pop;
    assign push_ok  = push && can_push;

    // Empty queue shows ID 0 so the FC never sees a stale entry.
    assign fc.valid = !status.empty;
    assign fc.data  = status.empty ? '0 : mem[rd_ptr_reg];

    // Storage array; entries are meaningful only between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Entry count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fc_event_rr_arb.sv
// Round-robin arbiter over the pending event sources.
// Grants at most one request per cycle while en is high. The search
// starts at the source after the last granted one (index 0 after reset).
module fc_event_rr_arb
    import fc_event_pkg::*;
#(
    parameter  int N     = NB_EVT_DEFAULT,
    localparam int IDX_W = idx_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] start_reg;
    logic [IDX_W-1:0] cand;

    // Walk the request vector from start_reg, wrapping at N, and pick the first hit.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(start_reg) + i >= N) begin
                cand = IDX_W'(int'(start_reg) + i - N);
            end else begin
                cand = IDX_W'(int'(start_reg) + i);
            end
            if (en && !grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Move the search start just past the winner so every source gets a turn.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_reg <= '0;
        end else if (grant_valid) begin
            if (grant_idx == IDX_W'(N-1)) begin
                start_reg <= '0;
            end else begin
                start_reg <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_event_queue.sv
// FC event queue: latches one-cycle event pulses per source, picks one
// pending source per cycle round-robin and queues its ID for the FC.
// Optional lost-event counting is enabled by defining
// FC_EVENT_QUEUE_DROP_CNT_EN; otherwise drop_cnt_o/overflow_o read 0.
module fc_event_queue
    import fc_event_pkg::*;
#(
    parameter int NB_EVT         = NB_EVT_DEFAULT,
    parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEFAULT,
    parameter int ID_OFFSET      = ID_OFFSET_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_EVT-1:0]         events_i,
    output logic                      event_fifo_valid_o,
    input  logic                      event_fifo_fulln_i,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic                      overflow_o
);

    localparam int IDX_W = idx_width(NB_EVT);

    logic [NB_EVT-1:0]         pending_reg;
    logic [NB_EVT-1:0]         pending_next;
    logic [NB_EVT-1:0]         grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      grant_valid;
    logic                      can_push;
    logic [EVENT_ID_WIDTH-1:0] push_id;

    fc_event_queue_if #(.EVENT_ID_WIDTH(EVENT_ID_WIDTH)) fc_bus ();

    assign event_fifo_valid_o = fc_bus.valid;
    assign event_fifo_data_o  = fc_bus.data;
    assign fc_bus.fulln       = event_fifo_fulln_i;

    // Arbitration is only enabled when the queue can take the winner this cycle.
    fc_event_rr_arb #(
        .N (NB_EVT)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req         (pending_reg),
        .en          (can_push),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A granted source is cleared, but a fresh pulse on the same edge re-arms it.
    generate
        for (genvar gi = 0; gi < NB_EVT; gi++) begin : g_pending
            assign pending_next[gi] = (pending_reg[gi] & ~grant[gi]) | events_i[gi];
        end
    endgenerate

    // Pending flag register, one bit per event source.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign push_id = EVENT_ID_WIDTH'(int'(grant_idx) + ID_OFFSET);

    fc_event_queue_fifo #(
        .EVENT_ID_WIDTH (EVENT_ID_WIDTH),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (grant_valid),
        .push_data (push_id),
        .can_push  (can_push),
        .fc        (fc_bus)
    );

`ifdef FC_EVENT_QUEUE_DROP_CNT_EN
    logic [NB_EVT-1:0] drop;
    int unsigned       drop_num;
    drop_cnt_t         drop_cnt_reg;
    logic              overflow_reg;

    // An event is lost when its source is already pending and not served this cycle.
    generate
        for (genvar gi = 0; gi < NB_EVT; gi++) begin : g_drop
            assign drop[gi] = events_i[gi] & pending_reg[gi] & ~grant[gi];
        end
    endgenerate

    // Number of events lost in the current cycle.
    always_comb begin
        drop_num = 0;
        for (int i = 0; i < NB_EVT; i++) begin
            drop_num = drop_num + {31'b0, drop[i]};
        end
    end

    // Saturating lost-event counter and its one-cycle overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            drop_cnt_reg <= drop_cnt_sat_add(drop_cnt_reg, drop_num);
            overflow_reg <= |drop;
        end
    end

    assign drop_cnt_o = drop_cnt_reg;
    assign overflow_o = overflow_reg;
`else
    assign drop_cnt_o = '0;
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fc_event_queue.sv
// Self-checking bench for fc_event_queue: a table of per-cycle vectors
// for latency and round-robin order, then hand-written sequences for
// back-pressure, full-queue push/pop, drop counting and mid-run reset.
// Delivered IDs are compared against a scoreboard queue.
module tb_fc_event_queue;
    import fc_event_pkg::*;

    localparam int NB = 32;
    localparam int W  = 8;
    localparam int D  = 4;

`ifdef FC_EVENT_QUEUE_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] events;
    logic [15:0]   drop_cnt;
    logic          overflow;

    always #5 clk = ~clk;

    fc_event_queue_if #(.EVENT_ID_WIDTH(W)) fc_if ();

    fc_event_queue #(
        .NB_EVT         (NB),
        .EVENT_ID_WIDTH (W),
        .FIFO_DEPTH     (D),
        .ID_OFFSET      (0)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .events_i           (events),
        .event_fifo_valid_o (fc_if.valid),
        .event_fifo_fulln_i (fc_if.fulln),
        .event_fifo_data_o  (fc_if.data),
        .drop_cnt_o         (drop_cnt),
        .overflow_o         (overflow)
    );

    typedef struct {
        logic [NB-1:0] ev;
        logic          fulln;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
    } vec_t;

    vec_t         vecs [16];
    logic [W-1:0] sb [$];
    bit           sb_on;
    int           checks;
    int           failures;
    int           exp_drop;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic int exp_cnt(input int v);
        return DROP_EN ? sat16(v) : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [NB-1:0] ev, input logic fulln,
                           input logic v, input logic [W-1:0] d);
        vecs[i].ev        = ev;
        vecs[i].fulln     = fulln;
        vecs[i].exp_valid = v;
        vecs[i].exp_data  = d;
    endtask

    // Monitor at the falling edge, then advance one rising edge and settle.
    task automatic tick();
        @(negedge clk);
        if (sb_on && fc_if.valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=0x%0h required=none", fc_if.data);
            end else begin
                check("sb_id", {24'b0, fc_if.data}, {24'b0, sb[0]});
                if (fc_if.fulln) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        events      = '0;
        fc_if.fulln = 1'b0;
        sb.delete();
        exp_drop    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sb_on    = 1'b0;
        exp_drop = 0;

        // Reset state, during and right after reset.
        rst_n       = 1'b0;
        events      = '0;
        fc_if.fulln = 1'b0;
        #2;
        check("rst_valid", {31'b0, fc_if.valid}, 32'd0);
        check("rst_data", {24'b0, fc_if.data}, 32'd0);
        check("rst_drop", {16'b0, drop_cnt}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'b0, fc_if.valid}, 32'd0);

        // Round-robin order (1,3,7 then 1 then 3,1) and 2-cycle latency on source 5.
        set_vec(0,  32'h0000_008A, 1'b1, 1'b0, 8'd0);
        set_vec(1,  32'h0,         1'b1, 1'b1, 8'd1);
        set_vec(2,  32'h0,         1'b1, 1'b1, 8'd3);
        set_vec(3,  32'h0,         1'b1, 1'b1, 8'd7);
        set_vec(4,  32'h0,         1'b1, 1'b0, 8'd0);
        set_vec(5,  32'h0000_0002, 1'b1, 1'b0, 8'd0);
        set_vec(6,  32'h0,         1'b1, 1'b1, 8'd1);
        set_vec(7,  32'h0,         1'b1, 1'b0, 8'd0);
        set_vec(8,  32'h0000_000A, 1'b1, 1'b0, 8'd0);
        set_vec(9,  32'h0,         1'b1, 1'b1, 8'd3);
        set_vec(10, 32'h0,         1'b1, 1'b1, 8'd1);
        set_vec(11, 32'h0,         1'b1, 1'b0, 8'd0);
        set_vec(12, 32'h0000_0020, 1'b1, 1'b0, 8'd0);
        set_vec(13, 32'h0,         1'b1, 1'b1, 8'd5);
        set_vec(14, 32'h0,         1'b1, 1'b0, 8'd0);
        set_vec(15, 32'h0,         1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            events      = vecs[i].ev;
            fc_if.fulln = vecs[i].fulln;
            tick();
            events = '0;
            check($sformatf("vec%0d_valid", i), {31'b0, fc_if.valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), {24'b0, fc_if.data}, {24'b0, vecs[i].exp_data});
            end
        end

        // Back-pressure: 6 sources, 4 queue, 2 stay pending, head stable, none lost.
        do_reset();
        sb_on  = 1'b1;
        events = (32'd1 << 2) | (32'd1 << 4) | (32'd1 << 9) | (32'd1 << 13) | (32'd1 << 20) | (32'd1 << 30);
        sb.push_back(8'd2);
        sb.push_back(8'd4);
        sb.push_back(8'd9);
        sb.push_back(8'd13);
        sb.push_back(8'd20);
        sb.push_back(8'd30);
        tick();
        events = '0;
        repeat (8) tick();
        check("bp_held_valid", {31'b0, fc_if.valid}, 32'd1);
        check("bp_held_count", sb.size(), 32'd6);
        fc_if.fulln = 1'b1;
        repeat (10) tick();
        check("bp_drained", sb.size(), 32'd0);
        check("bp_idle", {31'b0, fc_if.valid}, 32'd0);

        // Full queue with fulln high: push and pop together, 8 IDs back to back.
        do_reset();
        sb_on  = 1'b1;
        events = 32'h0000_00FF;
        for (int i = 0; i < 8; i++) sb.push_back(W'(i));
        tick();
        events = '0;
        repeat (6) tick();
        fc_if.fulln = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("pp_valid%0d", k), {31'b0, fc_if.valid}, (k < 8) ? 32'd1 : 32'd0);
        end
        check("pp_drained", sb.size(), 32'd0);

        // Drops on source 2 while the queue is full and the FC stalls.
        do_reset();
        sb_on  = 1'b1;
        events = 32'h0000_000F;
        for (int i = 0; i < 4; i++) sb.push_back(W'(i));
        tick();
        events = '0;
        repeat (6) tick();
        events = 32'h4;
        tick();
        events = '0;
        check("drop_first_cnt", {16'b0, drop_cnt}, 32'd0);
        check("drop_first_ovf", {31'b0, overflow}, 32'd0);
        events = 32'h4;
        tick();
        events = '0;
        exp_drop = exp_drop + 1;
        check("drop_second_cnt", {16'b0, drop_cnt}, exp_cnt(exp_drop));
        check("drop_second_ovf", {31'b0, overflow}, {31'b0, DROP_EN});
        tick();
        check("drop_ovf_clear", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            events = 32'h4;
            tick();
            exp_drop = exp_drop + 1;
            check($sformatf("drop_more%0d_ovf", i), {31'b0, overflow}, {31'b0, DROP_EN});
        end
        events = '0;
        tick();
        check("drop_four_cnt", {16'b0, drop_cnt}, exp_cnt(exp_drop));
        check("drop_four_ovf", {31'b0, overflow}, 32'd0);
        sb.push_back(8'd2);
        fc_if.fulln = 1'b1;
        repeat (10) tick();
        check("drop_drained", sb.size(), 32'd0);

        // Counter saturation: bring it to 16'hFFFE, then drop 3 more twice.
        do_reset();
        sb_on  = 1'b0;
        events = 32'h0000_000F;
        tick();
        events = '0;
        repeat (6) tick();
        events = '1;
        tick();
        check("sat_arm_cnt", {16'b0, drop_cnt}, 32'd0);
        for (int i = 0; i < 2047; i++) begin
            tick();
            exp_drop = sat16(exp_drop + 32);
        end
        events = 32'h3FFF_FFFF;
        tick();
        exp_drop = sat16(exp_drop + 30);
        check("sat_fffe", {16'b0, drop_cnt}, DROP_EN ? 32'h0000_FFFE : 32'd0);
        check("sat_fffe_model", {16'b0, drop_cnt}, exp_cnt(exp_drop));
        events = 32'h7;
        tick();
        check("sat_ffff", {16'b0, drop_cnt}, DROP_EN ? 32'h0000_FFFF : 32'd0);
        events = 32'h7;
        tick();
        events = '0;
        check("sat_hold", {16'b0, drop_cnt}, DROP_EN ? 32'h0000_FFFF : 32'd0);
        check("sat_ovf", {31'b0, overflow}, {31'b0, DROP_EN});

        // Reset mid-operation with 3 IDs queued and one drop counted.
        do_reset();
        sb_on  = 1'b0;
        events = 32'h0000_0060;
        tick();
        events = 32'h0000_0060;
        tick();
        events = '0;
        repeat (4) tick();
        check("mid_pre_valid", {31'b0, fc_if.valid}, 32'd1);
        check("mid_pre_data", {24'b0, fc_if.data}, 32'd5);
        check("mid_pre_drop", {16'b0, drop_cnt}, exp_cnt(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, fc_if.valid}, 32'd0);
        check("mid_rst_data", {24'b0, fc_if.data}, 32'd0);
        check("mid_rst_drop", {16'b0, drop_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        fc_if.fulln = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("mid_after%0d_valid", k), {31'b0, fc_if.valid}, 32'd0);
        end
        check("mid_after_drop", {16'b0, drop_cnt}, 32'd0);
        check("mid_after_ovf", {31'b0, overflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_event_queue.md
FC_EVENT_QUEUE -- requirements
Module: fc_event_queue

Interface
REQ-001 SHALL have parameter NB_EVT, default 32, number of event source lines.
REQ-002 SHALL have parameter EVENT_ID_WIDTH, default 8, width of the event ID sent to the FC interrupt controller.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-004 SHALL have parameter ID_OFFSET, default 0, added to the source index to form the event ID; NB_EVT+ID_OFFSET SHALL be at most 2^EVENT_ID_WIDTH.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port events_i, input, NB_EVT bits; each bit high for one cycle means one event.
REQ-008 SHALL have port event_fifo_valid_o, output, 1 bit, event ID available to the FC.
REQ-009 SHALL have port event_fifo_fulln_i, input, 1 bit, FC can accept (high means not full).
REQ-010 SHALL have port event_fifo_data_o, output, EVENT_ID_WIDTH bits, event ID.
REQ-011 SHALL have port drop_cnt_o, output, 16 bits, saturating count of lost events.
REQ-012 SHALL have port overflow_o, output, 1 bit, registered one-cycle pulse when at least one event was dropped in the previous cycle.

Function
REQ-013 SHALL keep one pending bit per source; the bit is set at the clock edge when events_i[k]=1.
REQ-014 SHALL use a round-robin arbiter that grants at most one pending source per cycle, and only when the queue can accept a push.
REQ-015 SHALL start the round-robin search at the source after the last granted one; after reset the search starts at index 0.
REQ-016 SHALL, on a grant of source k, push k+ID_OFFSET into the queue and clear pending[k] at the same edge.
REQ-017 SHALL, if events_i[k]=1 in the same cycle that source k is granted, leave pending[k] set so the new event is not lost.
REQ-018 SHALL count an event on source k as dropped when events_i[k]=1, pending[k]=1 and source k is not granted that cycle.
REQ-019 SHALL leave pending[k] set when an event is dropped.
REQ-020 SHALL allow a push when the queue is not full, or when it is full and a pop happens in the same cycle.
REQ-021 SHALL drive event_fifo_valid_o = queue not empty, and event_fifo_data_o = queue head.
REQ-022 SHALL pop when event_fifo_valid_o=1 and event_fifo_fulln_i=1.
REQ-023 SHALL keep event_fifo_data_o stable while event_fifo_valid_o=1 and event_fifo_fulln_i=0.
REQ-024 SHALL handle a push and a pop in the same cycle with the entry count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL have a latency of 2 cycles: an event at cycle t into an empty, idle queue gives event_fifo_valid_o=1 at cycle t+2.
REQ-026 SHALL produce only one valid cycle per event when event_fifo_fulln_i stays high (throughput 1 ID per cycle).

Reset
REQ-027 SHALL, on rst_ni low, asynchronously clear pending bits, queue pointers and count, the arbiter pointer, drop_cnt_o and overflow_o.
REQ-028 SHALL hold event_fifo_valid_o=0 and event_fifo_data_o=0 during and right after reset.
REQ-029 SHALL discard queued IDs when reset is asserted mid-operation; the first cycle after release SHALL be idle.

Configuration
REQ-030 SHALL implement drop counting only when macro FC_EVENT_QUEUE_DROP_CNT_EN is defined.
REQ-031 SHALL, with the macro defined, add the number of dropped events per cycle to drop_cnt_o, saturating at 16'hFFFF, and drive overflow_o as specified.
REQ-032 SHALL, without the macro, tie drop_cnt_o and overflow_o to 0 with no counter logic; all other behaviour is unchanged.

Structure
REQ-033 SHALL put the default parameter values and the drop-counter width constant (16) in the shared package fc_event_pkg.
REQ-034 SHALL implement the round-robin arbiter as sub-module fc_event_rr_arb (inputs: request vector, enable; outputs: one-hot grant, grant index).

Verification
REQ-035 SHALL check latency: pulse events_i[5] at cycle 10 with fulln=1 -> valid=1 and data=8'd5 at cycle 12 only.
REQ-036 SHALL check round-robin order: pulse events_i[3], [1] and [7] together with fulln=1 -> IDs 1, 3, 7 on consecutive cycles; then pulse [1] and [3] -> order 3, 1.
REQ-037 SHALL check back-pressure: hold fulln=0 and pulse 6 distinct sources -> 4 queued, 2 left pending, data stable; then release fulln -> all 6 IDs delivered, none lost.
REQ-038 SHALL check drops (macro defined): fulln=0, queue full, pulse events_i[2] twice -> drop_cnt_o=1, one overflow_o pulse; pulse 3 more times -> drop_cnt_o=4; preload count 16'hFFFE and drop 3 -> 16'hFFFF.
REQ-039 SHALL check simultaneous push and pop with a full queue and fulln=1 -> count stays at FIFO_DEPTH and IDs come out in order.
REQ-040 SHALL check reset mid-operation: assert rst_ni=0 with 3 IDs queued -> valid=0 at once; after release, no stale IDs and drop_cnt_o=0.
